addsub_checker: RTL and testbench

Self-checking response monitor for the 4-bit ripple adder/subtractor; it is the consuming end of the same A/B/Sel → Sum/Cout interface that the stimulus side drives. It samples each applied vector together with the adder's response, recomputes the expected result, and keeps vector and error counts. It captures the first failing vector and reports pass/fail once the programmed number of vectors has been checked. It sits beside the adder in simulation and on-board self-test, so stimulus loops need no waveform inspection.

---
 rtl/addsub_checker_if.sv | 32 +++
 rtl/addsub_checker.sv | 125 ++++++++++++
 tb/tb_addsub_checker.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_checker_if.sv
// addsub_checker_if
//   Vector bus between the adder/subtractor under test and its response
//   checker. One beat carries the applied operands together with the
//   adder's response.
//
//   Handshake: valid-only, no backpressure. When valid is high in a cycle,
//   a, b, sel, sum and cout together form one vector, and the consumer
//   takes it on that rising clock edge. There is no ready signal. The
//   producer may hold valid high every cycle.
//
//   Signals:
//     valid  1      vector present this cycle
//     a      WIDTH  operand a
//     b      WIDTH  operand b (before sel inversion)
//     sel    1      0 = add, 1 = subtract (a - b)
//     sum    WIDTH  adder result under test
//     cout   1      adder carry-out under test
//
//   Modports: master drives the vector (stimulus side), slave consumes it.
interface addsub_checker_if #(
  parameter int WIDTH = 4
);
  logic             valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output valid, a, b, sel, sum, cout);
  modport slave  (input  valid, a, b, sel, sum, cout);
endinterface

// File: rtl/addsub_checker.sv
// addsub_checker
//   Response monitor for a WIDTH-bit ripple adder/subtractor. Each vector
//   accepted while running is checked against a recomputed result. Vectors
//   and mismatches are counted, and the first failing vector is captured.
//   Done and Pass are reported after EXP_COUNT vectors.
//
//   Optional feature macro: CHECK_CARRY_EN
//     defined   -> a cout mismatch counts as an error
//     undefined -> only sum is compared; first_err_got still records cout
//
//   Ports:
//     clk            in   rising-edge clock
//     rst            in   asynchronous active-high reset
//     start          in   begin a run (taken in IDLE or DONE)
//     vec            slave modport of addsub_checker_if (valid/a/b/sel/sum/cout)
//     busy           out  high in RUN
//     done           out  high in DONE
//     pass           out  done & (err_count == 0)
//     vec_count      out  vectors checked this run (saturating)
//     err_count      out  mismatching vectors this run (saturating)
//     first_err_idx  out  vec_count value at the first mismatch
//     first_err_vec  out  {sel, a, b} of the first mismatch
//     first_err_got  out  {cout, sum} of the first mismatch
//     dbg_state      out  FSM state (0 IDLE, 1 RUN, 2 DONE)
module addsub_checker #(
  parameter int WIDTH     = 4,
  parameter int EXP_COUNT = 240
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  addsub_checker_if.slave      vec,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          vec_count,
  output logic [15:0]          err_count,
  output logic [15:0]          first_err_idx,
  output logic [2*WIDTH:0]     first_err_vec,
  output logic [WIDTH:0]       first_err_got,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(EXP_COUNT - 1);

  state_t state_q;
  state_t state_d;

  logic              first_seen_q;
  logic              take_start;
  logic              accept;
  logic              mismatch;
  logic [WIDTH-1:0]  sel_mask;

  assign sel_mask   = {WIDTH{vec.sel}};
  assign take_start = (state_q != RUN) && start;
  assign accept     = (state_q == RUN) && vec.valid;

`ifdef CHECK_CARRY_EN
  logic [WIDTH:0] exp_res;
  assign exp_res  = {1'b0, vec.a} + {1'b0, vec.b ^ sel_mask} + {{WIDTH{1'b0}}, vec.sel};
  assign mismatch = (vec.sum != exp_res[WIDTH-1:0]) || (vec.cout != exp_res[WIDTH]);
`else
  // Carry is not part of the comparison, so only the low WIDTH bits are formed.
  logic [WIDTH-1:0] exp_sum;
  assign exp_sum  = vec.a + (vec.b ^ sel_mask) + {{(WIDTH-1){1'b0}}, vec.sel};
  assign mismatch = (vec.sum != exp_sum);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && (vec_count == LAST_IDX)) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      first_seen_q  <= 1'b0;
      vec_count     <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_vec <= '0;
      first_err_got <= '0;
    end else begin
      state_q <= state_d;
      if (take_start) begin
        // A vector presented alongside start is deliberately not checked.
        first_seen_q  <= 1'b0;
        vec_count     <= '0;
        err_count     <= '0;
        first_err_idx <= '0;
        first_err_vec <= '0;
        first_err_got <= '0;
      end else if (accept) begin
        if (vec_count != 16'hFFFF) vec_count <= vec_count + 16'd1;
        if (mismatch) begin
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          if (!first_seen_q) begin
            first_seen_q  <= 1'b1;
            first_err_idx <= vec_count;
            first_err_vec <= {vec.sel, vec.a, vec.b};
            first_err_got <= {vec.cout, vec.sum};
          end
        end
      end
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_count == 16'd0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_addsub_checker.sv
module tb_addsub_checker;

  localparam int W    = 4;
  localparam int NVEC = 240;
  localparam int SB_W = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start1 = 1'b0;

  always #5 clk = ~clk;

  addsub_checker_if #(.WIDTH(W)) vif ();
  addsub_checker_if #(.WIDTH(W)) vif1 ();

  logic        busy, done, pass;
  logic [15:0] vec_count, err_count, first_err_idx;
  logic [8:0]  first_err_vec;
  logic [4:0]  first_err_got;
  logic [1:0]  dbg_state;

  logic        busy1, done1, pass1;
  logic [15:0] vec_count1, err_count1, first_err_idx1;
  logic [8:0]  first_err_vec1;
  logic [4:0]  first_err_got1;
  logic [1:0]  dbg_state1;

  addsub_checker #(.WIDTH(W), .EXP_COUNT(NVEC)) u_dut (
    .clk(clk), .rst(rst), .start(start), .vec(vif.slave),
    .busy(busy), .done(done), .pass(pass),
    .vec_count(vec_count), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_vec(first_err_vec),
    .first_err_got(first_err_got), .dbg_state(dbg_state)
  );

  addsub_checker #(.WIDTH(W), .EXP_COUNT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .vec(vif1.slave),
    .busy(busy1), .done(done1), .pass(pass1),
    .vec_count(vec_count1), .err_count(err_count1),
    .first_err_idx(first_err_idx1), .first_err_vec(first_err_vec1),
    .first_err_got(first_err_got1), .dbg_state(dbg_state1)
  );

  int errors = 0;
  int checks = 0;

  logic [SB_W-1:0] exp_q[$];

  // Canonical vector list: sel 0/1, a = 0..15, b < a.
  logic [3:0] la [NVEC];
  logic [3:0] lb [NVEC];
  logic       ls [NVEC];

  // Reference model state (0 IDLE, 1 RUN, 2 DONE).
  int          m_state;
  logic [15:0] m_vec, m_err, m_first_idx;
  logic        m_first_seen;
  logic [8:0]  m_first_vec;
  logic [4:0]  m_first_got;

  // Reference arithmetic: plain integer add, or a - b offset by 16 so that
  // bit 4 is 1 exactly when no borrow occurs.
  function automatic logic [4:0] calc(input logic [3:0] ia, input logic [3:0] ib, input logic is);
    int r;
    if (is) r = int'(ia) + 16 - int'(ib);
    else    r = int'(ia) + int'(ib);
    return r[4:0];
  endfunction

  task automatic build_list();
    int k = 0;
    for (int s = 0; s < 2; s++)
      for (int ia = 0; ia < 16; ia++)
        for (int ib = 0; ib < ia; ib++) begin
          la[k] = 4'(ia); lb[k] = 4'(ib); ls[k] = s[0];
          k++;
        end
  endtask

  task automatic model_clear();
    m_vec = '0; m_err = '0; m_first_idx = '0;
    m_first_seen = 1'b0; m_first_vec = '0; m_first_got = '0;
  endtask

  // One clock cycle: compare the outcome of the previous cycle, then drive
  // this cycle's inputs and push the expected outcome.
  task automatic step(input logic st, input logic v, input logic [3:0] ia, input logic [3:0] ib,
                      input logic is, input logic [3:0] isum, input logic ic);
    logic [SB_W-1:0] e;
    logic [4:0]      r;
    logic            bad;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({busy, done, vec_count, err_count} !== e) begin
        errors++;
        $display("FAIL sb_status got busy/done/vec/err=%h required=%h at %0t",
                 {busy, done, vec_count, err_count}, e, $time);
      end
    end
    start = st; vif.valid = v; vif.a = ia; vif.b = ib; vif.sel = is; vif.sum = isum; vif.cout = ic;
    r = calc(ia, ib, is);
`ifdef CHECK_CARRY_EN
    bad = (isum != r[3:0]) || (ic != r[4]);
`else
    bad = (isum != r[3:0]);
`endif
    if (m_state != 1) begin
      if (st) begin model_clear(); m_state = 1; end
    end else if (v) begin
      if (bad) begin
        if (!m_first_seen) begin
          m_first_seen = 1'b1; m_first_idx = m_vec;
          m_first_vec = {is, ia, ib}; m_first_got = {ic, isum};
        end
        if (m_err != 16'hFFFF) m_err++;
      end
      if (m_vec != 16'hFFFF) m_vec++;
      if (m_vec == 16'(NVEC)) m_state = 2;
    end
    exp_q.push_back({m_state == 1, m_state == 2, m_vec, m_err});
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic good_step(input logic st, input int i);
    logic [4:0] r;
    r = calc(la[i], lb[i], ls[i]);
    step(st, 1'b1, la[i], lb[i], ls[i], r[3:0], r[4]);
  endtask

  task automatic test_reset();
    vif.valid = 0; vif.a = 0; vif.b = 0; vif.sel = 0; vif.sum = 0; vif.cout = 0;
    vif1.valid = 0; vif1.a = 0; vif1.b = 0; vif1.sel = 0; vif1.sum = 0; vif1.cout = 0;
    rst = 1'b1;
    #1;
    checks++; if ({busy, done, pass} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b required=000", {busy, done, pass}); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d required=0", dbg_state); end
    checks++; if ({vec_count, err_count, first_err_idx} !== 48'h0) begin errors++; $display("FAIL reset_counts got=%h required=0", {vec_count, err_count, first_err_idx}); end
    checks++; if ({first_err_vec, first_err_got} !== 14'h0) begin errors++; $display("FAIL reset_first got=%h required=0", {first_err_vec, first_err_got}); end
    m_state = 0; model_clear(); exp_q.delete();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_full_pass();
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < NVEC; i++) good_step(1'b0, i);
    idle_step();
    checks++; if ({done, pass} !== 2'b11) begin errors++; $display("FAIL full_done_pass got=%b required=11", {done, pass}); end
    checks++; if (vec_count !== 16'd240 || err_count !== 16'd0) begin errors++; $display("FAIL full_counts got vec=%0d err=%0d required vec=240 err=0", vec_count, err_count); end
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL full_state got=%0d required=2", dbg_state); end
  endtask

  task automatic test_first_error();
    logic [4:0] r;
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < NVEC; i++) begin
      if (i == 7) step(1'b0, 1'b1, 4'h5, 4'h3, 1'b1, 4'h0, 1'b1);
      else if (i == 50) begin
        r = calc(la[i], lb[i], ls[i]);
        step(1'b0, 1'b1, la[i], lb[i], ls[i], r[3:0] ^ 4'h4, r[4]);
      end else good_step(1'b0, i);
    end
    idle_step();
    checks++; if (err_count !== 16'd2) begin errors++; $display("FAIL ferr_count got=%0d required=2", err_count); end
    checks++; if (first_err_idx !== 16'd7) begin errors++; $display("FAIL ferr_idx got=%0d required=7", first_err_idx); end
    checks++; if (first_err_vec !== 9'h153) begin errors++; $display("FAIL ferr_vec got=%h required=153", first_err_vec); end
    checks++; if (first_err_got !== 5'h10) begin errors++; $display("FAIL ferr_got got=%h required=10", first_err_got); end
    checks++; if ({done, pass} !== 2'b10) begin errors++; $display("FAIL ferr_pass got=%b required=10", {done, pass}); end
  endtask

  task automatic test_carry();
    logic [15:0] want_err;
`ifdef CHECK_CARRY_EN
    want_err = 16'd1;
`else
    want_err = 16'd0;
`endif
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 4'h9, 4'h8, 1'b0, 4'h1, 1'b0);
    for (int i = 1; i < NVEC; i++) good_step(1'b0, i);
    idle_step();
    checks++; if (err_count !== want_err) begin errors++; $display("FAIL carry_err got=%0d required=%0d", err_count, want_err); end
    checks++; if (pass !== (want_err == 16'd0)) begin errors++; $display("FAIL carry_pass got=%b required=%b", pass, want_err == 16'd0); end
    checks++; if (first_err_got !== m_first_got || first_err_idx !== m_first_idx) begin errors++; $display("FAIL carry_first got=%h/%0d required=%h/%0d", first_err_got, first_err_idx, m_first_got, m_first_idx); end
  endtask

  task automatic test_idle_valid_midrun_start();
    test_reset();
    for (int i = 0; i < 3; i++) good_step(1'b0, i + 20);
    step(1'b1, 1'b1, 4'h2, 4'h1, 1'b0, 4'hF, 1'b1);
    checks++; if (dbg_state !== 2'd0 || vec_count !== 16'd0) begin errors++; $display("FAIL idle_valid got state=%0d vec=%0d required state=0 vec=0", dbg_state, vec_count); end
    for (int i = 0; i < NVEC; i++) good_step(i == 50 || i == 51, i);
    idle_step();
    checks++; if (vec_count !== 16'd240 || err_count !== 16'd0) begin errors++; $display("FAIL midrun_counts got vec=%0d err=%0d required vec=240 err=0", vec_count, err_count); end
    checks++; if ({done, pass} !== 2'b11) begin errors++; $display("FAIL midrun_done got=%b required=11", {done, pass}); end
  endtask

  task automatic test_reset_midrun();
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 100; i++) good_step(1'b0, i);
    idle_step();
    checks++; if (vec_count !== 16'd100 || busy !== 1'b1) begin errors++; $display("FAIL pre_rst got vec=%0d busy=%b required vec=100 busy=1", vec_count, busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({busy, done, pass, dbg_state} !== 5'b0) begin errors++; $display("FAIL rst_mid_flags got=%b required=00000", {busy, done, pass, dbg_state}); end
    checks++; if ({vec_count, err_count, first_err_idx, first_err_vec, first_err_got} !== 62'h0) begin errors++; $display("FAIL rst_mid_regs got=%h required=0", {vec_count, err_count, first_err_idx, first_err_vec, first_err_got}); end
    exp_q.delete(); m_state = 0; model_clear();
    @(negedge clk); rst = 1'b0;
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < NVEC; i++) good_step(1'b0, i);
    idle_step();
    checks++; if (vec_count !== 16'd240 || done !== 1'b1) begin errors++; $display("FAIL rst_rerun got vec=%0d done=%b required vec=240 done=1", vec_count, done); end
  endtask

  task automatic test_exp_one();
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    vif1.valid = 1'b1; vif1.a = 4'h3; vif1.b = 4'h1; vif1.sel = 1'b0; vif1.sum = 4'h4; vif1.cout = 1'b0;
    checks++; if ({busy1, done1} !== 2'b10) begin errors++; $display("FAIL one_busy got=%b required=10", {busy1, done1}); end
    @(negedge clk); vif1.valid = 1'b0;
    checks++; if ({busy1, done1, pass1} !== 3'b011) begin errors++; $display("FAIL one_done got=%b required=011", {busy1, done1, pass1}); end
    checks++; if (vec_count1 !== 16'd1 || err_count1 !== 16'd0) begin errors++; $display("FAIL one_counts got vec=%0d err=%0d required vec=1 err=0", vec_count1, err_count1); end
  endtask

  task automatic final_flush();
    logic [SB_W-1:0] e;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({busy, done, vec_count, err_count} !== e) begin
        errors++;
        $display("FAIL sb_flush got=%h required=%h", {busy, done, vec_count, err_count}, e);
      end
    end
  endtask

  initial begin
    build_list();
    test_reset();
    test_full_pass();
    test_first_error();
    test_carry();
    test_idle_valid_midrun_start();
    test_reset_midrun();
    test_exp_one();
    final_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
